// File: rtl/bgm_pkg.sv
// Shared types and constants for the background-music sequencer.
// Contents:
//   state_e       sequencer FSM states
//   FETCH_CYCLES  cycles spent addressing the note table before sampling it
//   calc_ticks    clock cycles per duration unit
//   calc_cnt_w    counter width for a 0..ticks-1 counter (minimum 1 bit)
package bgm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StPlay,
        StPause,
        StDone
    } state_e;

    localparam int unsigned FETCH_CYCLES = 2;

    function automatic int unsigned calc_ticks(input int unsigned clk_hz,
                                               input int unsigned units_per_sec);
        return clk_hz / units_per_sec;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/bgm_tone_gen.sv
// Square-wave tone generator: toggles its output every `period_i` enabled cycles.
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   enable_i  advance the half-period counter this cycle
//   load_i    start of a new note: clear counter, output low
//   period_i  half-period in clocks; 0 = rest (output held low)
//   tone_o    square wave
module bgm_tone_gen #(
    parameter int unsigned PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tone_o
);

    logic [PERIOD_W-1:0] half_cnt_q, half_cnt_d;
    logic                tone_q, tone_d;

    always_comb begin
        half_cnt_d = half_cnt_q;
        tone_d     = tone_q;
        if (load_i) begin
            half_cnt_d = '0;
            tone_d     = 1'b0;
        end else if (enable_i && (period_i != '0)) begin
            if (half_cnt_q == period_i - PERIOD_W'(1)) begin
                half_cnt_d = '0;
                tone_d     = ~tone_q;
            end else begin
                half_cnt_d = half_cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            tone_q     <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/bgm_sequencer.sv
// Background-music sequencer: walks an external note table, playing each note's
// square wave for dur*TICKS cycles, with rests, end marker, loop, pause and done pulse.
// Optional macro BGM_VOLUME_EN adds volume_i and a 3-bit PWM frame counter.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   volume_i        (BGM_VOLUME_EN only) 0 = mute .. 7 = 7/8 duty
//   play_i          level: run; low stops and rewinds to note 0
//   pause_i         level: freeze playback while playing
//   loop_en_i       at end marker: 1 = restart, 0 = stop
//   note_idx_o      note table address
//   note_period_i   half-period for note_idx_o (0 = rest)
//   note_dur_i      duration in units for note_idx_o (0 = end of song)
//   audio_out_o     audio pin
//   aud_sd_o        amplifier enable
//   busy_o          high in FETCH/PLAY/PAUSE
//   song_done_o     one-cycle pulse when a one-shot song ends
module bgm_sequencer
    import bgm_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned UNITS_PER_SEC = 16,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned PERIOD_W      = 20,
    parameter int unsigned DUR_W         = 5
) (
    input  logic                clk,
    input  logic                reset,
`ifdef BGM_VOLUME_EN
    input  logic [2:0]          volume_i,
`endif
    input  logic                play_i,
    input  logic                pause_i,
    input  logic                loop_en_i,
    output logic [ADDR_W-1:0]   note_idx_o,
    input  logic [PERIOD_W-1:0] note_period_i,
    input  logic [DUR_W-1:0]    note_dur_i,
    output logic                audio_out_o,
    output logic                aud_sd_o,
    output logic                busy_o,
    output logic                song_done_o
);

    localparam int unsigned TICKS  = calc_ticks(CLK_HZ, UNITS_PER_SEC);
    localparam int unsigned UNIT_W = calc_cnt_w(TICKS);

    state_e              state_q, state_d;
    state_e              ret_q, ret_d;      // state to resume after PAUSE
    state_e              eff_state;
    logic                fetch_cnt_q, fetch_cnt_d;
    logic [UNIT_W-1:0]   unit_cnt_q, unit_cnt_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [ADDR_W-1:0]   note_idx_q, note_idx_d;
    logic                done_seen_q;
    logic                tone_en, tone_load, tone;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ret_q       <= StFetch;
            fetch_cnt_q <= 1'b0;
            unit_cnt_q  <= '0;
            dur_cnt_q   <= '0;
            period_q    <= '0;
            dur_q       <= '0;
            note_idx_q  <= '0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            fetch_cnt_q <= fetch_cnt_d;
            unit_cnt_q  <= unit_cnt_d;
            dur_cnt_q   <= dur_cnt_d;
            period_q    <= period_d;
            dur_q       <= dur_d;
            note_idx_q  <= note_idx_d;
            done_seen_q <= (state_q == StDone);
        end
    end

    // Next state and datapath. The cycle that leaves PAUSE already runs the
    // interrupted state's logic, so only pause-high cycles are lost.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        fetch_cnt_d = fetch_cnt_q;
        unit_cnt_d  = unit_cnt_q;
        dur_cnt_d   = dur_cnt_q;
        period_d    = period_q;
        dur_d       = dur_q;
        note_idx_d  = note_idx_q;
        tone_en     = 1'b0;
        tone_load   = 1'b0;
        eff_state   = (state_q == StPause) ? ret_q : state_q;

        if (!play_i) begin
            state_d     = StIdle;
            note_idx_d  = '0;
            fetch_cnt_d = 1'b0;
            unit_cnt_d  = '0;
            dur_cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d     = StFetch;
                    fetch_cnt_d = 1'b0;
                end
                StDone: state_d = StDone;
                StFetch, StPlay, StPause: begin
                    if (pause_i) begin
                        state_d = StPause;
                        ret_d   = eff_state;
                    end else if (eff_state == StFetch) begin
                        state_d = StFetch;
                        if (fetch_cnt_q != 1'(FETCH_CYCLES - 1)) begin
                            fetch_cnt_d = fetch_cnt_q + 1'b1;
                        end else begin
                            fetch_cnt_d = 1'b0;
                            if (note_dur_i == '0) begin
                                if (loop_en_i) begin
                                    note_idx_d = '0;
                                end else begin
                                    state_d = StDone;
                                end
                            end else begin
                                period_d   = note_period_i;
                                dur_d      = note_dur_i;
                                unit_cnt_d = '0;
                                dur_cnt_d  = '0;
                                tone_load  = 1'b1;
                                state_d    = StPlay;
                            end
                        end
                    end else begin
                        state_d = StPlay;
                        tone_en = 1'b1;
                        if (unit_cnt_q == UNIT_W'(TICKS - 1)) begin
                            unit_cnt_d = '0;
                            if (dur_cnt_q + DUR_W'(1) == dur_q) begin
                                dur_cnt_d  = '0;
                                note_idx_d = note_idx_q + ADDR_W'(1);
                                state_d    = StFetch;
                            end else begin
                                dur_cnt_d = dur_cnt_q + DUR_W'(1);
                            end
                        end else begin
                            unit_cnt_d = unit_cnt_q + UNIT_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    bgm_tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone_gen (
        .clk      (clk),
        .reset    (reset),
        .enable_i (tone_en),
        .load_i   (tone_load),
        .period_i (period_q),
        .tone_o   (tone)
    );

`ifdef BGM_VOLUME_EN
    logic [2:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + 3'd1;
        end
    end
`endif

    // Outputs.
    always_comb begin
        busy_o      = (state_q == StFetch) || (state_q == StPlay) || (state_q == StPause);
        aud_sd_o    = busy_o;
        song_done_o = (state_q == StDone) && !done_seen_q;
        note_idx_o  = note_idx_q;
`ifdef BGM_VOLUME_EN
        audio_out_o = tone && (state_q == StPlay) && (frame_cnt_q < volume_i);
`else
        audio_out_o = tone && (state_q == StPlay);
`endif
    end

endmodule

// File: tb/tb_bgm_sequencer.sv
// Self-checking bench for bgm_sequencer (TICKS = 10). Each queue entry holds the
// inputs for one clock edge and the outputs required after that edge.
module tb_bgm_sequencer;

    localparam int AW = 10;
    localparam int PW = 20;
    localparam int DW = 5;
    localparam int TICKS = 10;
`ifdef BGM_VOLUME_EN
    localparam bit Muted = 1'b1;
`else
    localparam bit Muted = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        play;
        logic        pause;
        logic        loop_en;
        logic [13:0] exp;   // {song_done, busy, aud_sd, audio, note_idx}
    } step_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          play = 1'b0;
    logic          pause = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] note_idx;
    logic [PW-1:0] note_period;
    logic [DW-1:0] note_dur;
    logic          audio_out, aud_sd, busy, song_done;
    logic [13:0]   obs;
`ifdef BGM_VOLUME_EN
    logic [2:0]    volume = 3'd0;
`endif

    logic [PW-1:0] tbl_p [16];
    logic [DW-1:0] tbl_d [16];

    step_t sb[$];
    step_t st;
    logic  cur_rst, cur_play, cur_pause, cur_loop;
    int    n_cmp = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    assign note_period = tbl_p[note_idx[3:0]];
    assign note_dur    = tbl_d[note_idx[3:0]];
    assign obs = {song_done, busy, aud_sd, audio_out, note_idx};

    bgm_sequencer #(
        .CLK_HZ        (160),
        .UNITS_PER_SEC (16),
        .ADDR_W        (AW),
        .PERIOD_W      (PW),
        .DUR_W         (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef BGM_VOLUME_EN
        .volume_i      (volume),
`endif
        .play_i        (play),
        .pause_i       (pause),
        .loop_en_i     (loop_en),
        .note_idx_o    (note_idx),
        .note_period_i (note_period),
        .note_dur_i    (note_dur),
        .audio_out_o   (audio_out),
        .aud_sd_o      (aud_sd),
        .busy_o        (busy),
        .song_done_o   (song_done)
    );

    // ---- expectation builders ----
    task automatic push(input logic d, input logic b, input logic a, input int idx);
        step_t s;
        s.rst = cur_rst; s.play = cur_play; s.pause = cur_pause; s.loop_en = cur_loop;
        s.exp = {d, b, b, a, 10'(idx)};
        sb.push_back(s);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic push_fetch(input int idx);
        for (int i = 0; i < 2; i++) push(1'b0, 1'b1, 1'b0, idx);
    endtask

    // j counts tone-advancing PLAY cycles since note load.
    task automatic push_play(input int p, input int j0, input int n, input int idx);
        logic a;
        for (int j = j0; j < j0 + n; j++) begin
            a = (p == 0) ? 1'b0 : 1'(((j / p) % 2) == 1);
            push(1'b0, 1'b1, a & ~Muted, idx);
        end
    endtask

    task automatic push_pause(input int n, input int idx);
        cur_pause = 1'b1;
        for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b0, idx);
        cur_pause = 1'b0;
    endtask

    task automatic push_done(input int idx, input int n);
        push(1'b1, 1'b0, 1'b0, idx);
        for (int i = 1; i < n; i++) push(1'b0, 1'b0, 1'b0, idx);
    endtask

    task automatic apply(input step_t s);
        reset = s.rst; play = s.play; pause = s.pause; loop_en = s.loop_en;
    endtask

    task automatic set_table(input int p0, input int d0, input int p1, input int d1,
                             input int p2, input int d2);
        for (int i = 0; i < 16; i++) begin tbl_p[i] = '0; tbl_d[i] = '0; end
        tbl_p[0] = PW'(p0); tbl_d[0] = DW'(d0);
        tbl_p[1] = PW'(p1); tbl_d[1] = DW'(d1);
        tbl_p[2] = PW'(p2); tbl_d[2] = DW'(d2);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        int k = 0;
        cur_rst = 1'b1; cur_play = 1'b0; cur_pause = 1'b0; cur_loop = 1'b0;
        push_idle(2);
        cur_rst = 1'b0;
        push_idle(2);
        while (sb.size() != 0) begin
            st = sb.pop_front(); apply(st); @(posedge clk); #1; n_cmp++; k++;
            if (obs !== st.exp) begin
                n_fail++;
                $display("FAIL reset step %0d: got %h want %h ({done,busy,sd,audio,idx})",
                         k, obs, st.exp);
            end
        end
    endtask

    task automatic test_one_shot();
        int k = 0;
        set_table(3, 2, 0, 0, 0, 0);
        cur_loop = 1'b0; cur_play = 1'b1;
        push_fetch(0); push_play(3, 0, 2 * TICKS, 0); push_fetch(1); push_done(1, 4);
        cur_play = 1'b0;
        push_idle(2);
        while (sb.size() != 0) begin
            st = sb.pop_front(); apply(st); @(posedge clk); #1; n_cmp++; k++;
            if (obs !== st.exp) begin
                n_fail++;
                $display("FAIL one_shot step %0d: got %h want %h ({done,busy,sd,audio,idx})",
                         k, obs, st.exp);
            end
        end
    endtask

    task automatic test_loop();
        int k = 0;
        set_table(3, 2, 0, 0, 0, 0);
        cur_loop = 1'b1; cur_play = 1'b1;
        push_fetch(0); push_play(3, 0, 2 * TICKS, 0); push_fetch(1);
        push_fetch(0); push_play(3, 0, 2 * TICKS, 0); push_fetch(1);
        push_fetch(0); push_play(3, 0, 5, 0);
        cur_play = 1'b0; cur_loop = 1'b0;
        push_idle(2);
        while (sb.size() != 0) begin
            st = sb.pop_front(); apply(st); @(posedge clk); #1; n_cmp++; k++;
            if (obs !== st.exp) begin
                n_fail++;
                $display("FAIL loop step %0d: got %h want %h ({done,busy,sd,audio,idx})",
                         k, obs, st.exp);
            end
        end
    endtask

    task automatic test_rest();
        int k = 0;
        set_table(0, 1, 0, 0, 0, 0);
        cur_play = 1'b1;
        push_fetch(0); push_play(0, 0, TICKS, 0); push_fetch(1); push_done(1, 2);
        cur_play = 1'b0;
        push_idle(1);
        while (sb.size() != 0) begin
            st = sb.pop_front(); apply(st); @(posedge clk); #1; n_cmp++; k++;
            if (obs !== st.exp) begin
                n_fail++;
                $display("FAIL rest step %0d: got %h want %h ({done,busy,sd,audio,idx})",
                         k, obs, st.exp);
            end
        end
    endtask

    // 5 PLAY cycles, 7 paused, 5 PLAY cycles: 17 cycles before the next FETCH.
    task automatic test_pause();
        int k = 0;
        set_table(3, 1, 0, 0, 0, 0);
        cur_play = 1'b1;
        push_fetch(0); push_play(3, 0, 5, 0); push_pause(7, 0); push_play(3, 5, 5, 0);
        push_fetch(1); push_done(1, 2);
        cur_play = 1'b0;
        push_idle(1);
        while (sb.size() != 0) begin
            st = sb.pop_front(); apply(st); @(posedge clk); #1; n_cmp++; k++;
            if (obs !== st.exp) begin
                n_fail++;
                $display("FAIL pause step %0d: got %h want %h ({done,busy,sd,audio,idx})",
                         k, obs, st.exp);
            end
        end
    endtask

    task automatic test_back_to_back_play_drop();
        int k = 0;
        set_table(2, 1, 3, 2, 0, 0);
        cur_play = 1'b1;
        push_fetch(0); push_play(2, 0, TICKS, 0); push_fetch(1); push_play(3, 0, 7, 1);
        cur_play = 1'b0;
        push_idle(2);
        cur_play = 1'b1;
        push_fetch(0); push_play(2, 0, TICKS, 0); push_fetch(1); push_play(3, 0, 3, 1);
        cur_play = 1'b0;
        push_idle(1);
        while (sb.size() != 0) begin
            st = sb.pop_front(); apply(st); @(posedge clk); #1; n_cmp++; k++;
            if (obs !== st.exp) begin
                n_fail++;
                $display("FAIL play_drop step %0d: got %h want %h ({done,busy,sd,audio,idx})",
                         k, obs, st.exp);
            end
        end
    endtask

    task automatic test_reset_mid_note();
        int k = 0;
        set_table(3, 2, 0, 0, 0, 0);
        cur_play = 1'b1;
        push_fetch(0); push_play(3, 0, 8, 0);
        cur_rst = 1'b1;
        push_idle(1);
        cur_rst = 1'b0;
        push_fetch(0); push_play(3, 0, 4, 0);
        cur_play = 1'b0;
        push_idle(1);
        while (sb.size() != 0) begin
            st = sb.pop_front(); apply(st); @(posedge clk); #1; n_cmp++; k++;
            if (obs !== st.exp) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h want %h ({done,busy,sd,audio,idx})",
                         k, obs, st.exp);
            end
        end
    endtask

    initial begin
        set_table(0, 0, 0, 0, 0, 0);
        test_reset();
        test_one_shot();
        test_loop();
        test_rest();
        test_pause();
        test_back_to_back_play_drop();
        test_reset_mid_note();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
